// File: rtl/pgc_pkg.sv
// Shared constants and helpers for the layer compositor: colour names,
// default palette and config address width.
package pgc_pkg;

  localparam int PGC_COLOR_W = 12;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hfff;
  localparam logic [11:0] RED   = 12'h00f;
  localparam logic [11:0] BLUE  = 12'h0f0;
  localparam logic [11:0] CYAN  = 12'hff0;

  // Only the 12-bit build has a distinct palette; other widths use all-ones.
  function automatic logic [31:0] default_layer_colour(input int idx, input int cw);
    logic [31:0] ones;
    ones = (cw >= 32) ? 32'hffff_ffff : ((32'd1 << cw) - 32'd1);
    if (cw != 12) return ones;
    case (idx)
      0:       return {20'd0, BLUE};
      1:       return {20'd0, CYAN};
      2:       return {20'd0, RED};
      default: return {20'd0, WHITE};
    endcase
  endfunction

  function automatic int cfg_aw(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < n + 3) r = k + 1;
    return r;
  endfunction

endpackage

// File: rtl/pgc_layer_compositor_if.sv
// Configuration write channel for the layer compositor.
interface pgc_cfg_if #(
  parameter int AW = 4,
  parameter int DW = 12
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/pgc_layer_compositor_priority_enc.sv
// Lowest-index-first priority encoder with an all-clear flag.
module pgc_priority_enc #(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_none
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IW'(i);
  end

  assign o_none = ~|i_req;

endmodule

// File: rtl/pgc_layer_compositor.sv
// Prioritised layer compositor with double-buffered palette and 2-stage output.
// Optional blink support is built when PGC_BLINK_EN is defined.
module pgc_layer_compositor
  import pgc_pkg::*;
#(
  parameter int NUM_LAYERS   = 6,
  parameter int COLOR_W      = PGC_COLOR_W,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LAYERS-1:0] layer_on,
  input  logic                  video_on,
  input  logic                  frame_tick,
  pgc_cfg_if.slave              cfg,
  output logic [COLOR_W-1:0]    rgb,
  output logic                  rgb_valid
);

  localparam int AW = cfg_aw(NUM_LAYERS);
  localparam int IW = $clog2(NUM_LAYERS);
  localparam logic [AW-1:0] A_BG = AW'(NUM_LAYERS);
  localparam logic [AW-1:0] A_EN = AW'(NUM_LAYERS + 1);

  if (NUM_LAYERS < 2 || NUM_LAYERS > COLOR_W || BLINK_FRAMES < 1) begin : g_bad_param
    $error("pgc_layer_compositor: illegal parameter set");
  end

  logic [COLOR_W-1:0]    r_sh_col  [NUM_LAYERS];
  logic [COLOR_W-1:0]    r_ac_col  [NUM_LAYERS];
  logic [COLOR_W-1:0]    r_pal_col [NUM_LAYERS];
  logic [COLOR_W-1:0]    r_sh_bg, r_ac_bg, r_pal_bg;
  logic [NUM_LAYERS-1:0] r_sh_en, r_ac_en;
  logic [NUM_LAYERS-1:0] r_eff_on;
  logic                  r_vid_d;
  logic                  w_wr;
  logic [NUM_LAYERS-1:0] w_eff_on;
  logic [IW-1:0]         w_idx;
  logic                  w_none;

  assign cfg.cfg_ready = ~frame_tick;
  assign w_wr          = cfg.cfg_valid & ~frame_tick;

  // Shadow set takes writes; active set is reloaded whole on frame_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_sh_col[i] <= COLOR_W'(default_layer_colour(i, COLOR_W));
        r_ac_col[i] <= COLOR_W'(default_layer_colour(i, COLOR_W));
      end
      r_sh_bg <= '0;
      r_ac_bg <= '0;
      r_sh_en <= '1;
      r_ac_en <= '1;
    end else begin
      if (w_wr) begin
        for (int i = 0; i < NUM_LAYERS; i++)
          if (cfg.cfg_addr == AW'(i)) r_sh_col[i] <= cfg.cfg_data;
        if (cfg.cfg_addr == A_BG) r_sh_bg <= cfg.cfg_data;
        if (cfg.cfg_addr == A_EN) r_sh_en <= cfg.cfg_data[NUM_LAYERS-1:0];
      end
      if (frame_tick) begin
        r_ac_col <= r_sh_col;
        r_ac_bg  <= r_sh_bg;
        r_ac_en  <= r_sh_en;
      end
    end
  end

`ifdef PGC_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW-1:0] A_BLINK = AW'(NUM_LAYERS + 2);

  logic [NUM_LAYERS-1:0] r_sh_blink, r_ac_blink;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_blink    <= '0;
      r_ac_blink    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      if (w_wr && cfg.cfg_addr == A_BLINK) r_sh_blink <= cfg.cfg_data[NUM_LAYERS-1:0];
      if (frame_tick) begin
        r_ac_blink <= r_sh_blink;
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign w_eff_on = layer_on & r_ac_en & ~(r_ac_blink & {NUM_LAYERS{~r_blink_phase}});
`else
  assign w_eff_on = layer_on & r_ac_en;
`endif

  pgc_priority_enc #(.N(NUM_LAYERS), .IW(IW)) u_prio (
    .i_req  (r_eff_on),
    .o_idx  (w_idx),
    .o_none (w_none)
  );

  // Stage 2 reads a one-cycle-delayed palette so colours and masks switch on
  // the same pixel: the first one entering stage 1 after the commit cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_eff_on  <= '0;
      r_vid_d   <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++)
        r_pal_col[i] <= COLOR_W'(default_layer_colour(i, COLOR_W));
      r_pal_bg  <= '0;
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      r_eff_on  <= w_eff_on;
      r_vid_d   <= video_on;
      r_pal_col <= r_ac_col;
      r_pal_bg  <= r_ac_bg;
      rgb_valid <= r_vid_d;
      if (!r_vid_d)    rgb <= '0;
      else if (w_none) rgb <= r_pal_bg;
      else             rgb <= r_pal_col[w_idx];
    end
  end

endmodule

// File: tb/tb_pgc_layer_compositor.sv
// Directed bench for pgc_layer_compositor with a frame-level reference model.
module tb_pgc_layer_compositor;

  logic        clk;
  logic        reset;
  logic [5:0]  layer_on;
  logic        video_on;
  logic        frame_tick;
  logic [11:0] rgb;
  logic        rgb_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;
  logic chk_en = 1'b0;

  pgc_cfg_if #(.AW(4), .DW(12)) cfg_bus ();

  pgc_layer_compositor #(.NUM_LAYERS(6), .COLOR_W(12), .BLINK_FRAMES(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .layer_on   (layer_on),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .cfg        (cfg_bus),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PGC_BLINK_EN
  localparam logic [11:0] BLINK_OFF_EXP = 12'h5a5;
`else
  localparam logic [11:0] BLINK_OFF_EXP = 12'h0f0;
`endif

  // Reference model: register file semantics plus per-pixel colour choice.
  logic [11:0] def_col [6] = '{12'h0f0, 12'hff0, 12'h00f, 12'hfff, 12'hfff, 12'hfff};
  logic [11:0] m_sh_col [6];
  logic [11:0] m_ac_col [6];
  logic [11:0] m_sh_bg, m_ac_bg;
  logic [5:0]  m_sh_en, m_ac_en;
  logic [5:0]  m_sh_bl, m_ac_bl;
  int          m_ticks;
  logic [11:0] m_p1_rgb, m_p2_rgb;
  logic        m_p1_v, m_p2_v;

  function automatic logic [11:0] pix_colour(input logic vid, input logic [5:0] lon);
    logic [5:0] eff;
    eff = lon & m_ac_en;
`ifdef PGC_BLINK_EN
    if (((m_ticks / 30) % 2) != 0) eff = eff & ~m_ac_bl;
`endif
    if (!vid) return 12'h000;
    for (int i = 0; i < 6; i++)
      if (eff[i]) return m_ac_col[i];
    return m_ac_bg;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        m_sh_col[i] <= def_col[i];
        m_ac_col[i] <= def_col[i];
      end
      m_sh_bg  <= 12'h000;  m_ac_bg <= 12'h000;
      m_sh_en  <= 6'h3f;    m_ac_en <= 6'h3f;
      m_sh_bl  <= 6'h00;    m_ac_bl <= 6'h00;
      m_ticks  <= 0;
      m_p1_rgb <= 12'h000;  m_p1_v  <= 1'b0;
      m_p2_rgb <= 12'h000;  m_p2_v  <= 1'b0;
    end else begin
      m_p1_rgb <= pix_colour(video_on, layer_on);
      m_p1_v   <= video_on;
      m_p2_rgb <= m_p1_rgb;
      m_p2_v   <= m_p1_v;
      if (cfg_bus.cfg_valid && !frame_tick) begin
        if (cfg_bus.cfg_addr < 4'd6)       m_sh_col[cfg_bus.cfg_addr] <= cfg_bus.cfg_data;
        else if (cfg_bus.cfg_addr == 4'd6) m_sh_bg <= cfg_bus.cfg_data;
        else if (cfg_bus.cfg_addr == 4'd7) m_sh_en <= cfg_bus.cfg_data[5:0];
`ifdef PGC_BLINK_EN
        else if (cfg_bus.cfg_addr == 4'd8) m_sh_bl <= cfg_bus.cfg_data[5:0];
`endif
      end
      if (frame_tick) begin
        m_ac_col <= m_sh_col;
        m_ac_bg  <= m_sh_bg;
        m_ac_en  <= m_sh_en;
        m_ac_bl  <= m_sh_bl;
        m_ticks  <= m_ticks + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (rgb !== m_p2_rgb || rgb_valid !== m_p2_v) begin
        n_fail++;
        $display("FAIL pipe t=%0t: rgb=%h valid=%b, expected rgb=%h valid=%b",
                 $time, rgb, rgb_valid, m_p2_rgb, m_p2_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] addr, input logic [11:0] data);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_data  = data;
    cyc();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    tick_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; video_on = 1'b0; layer_on = '0; frame_tick = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_valid", 32'(rgb_valid), 32'h0);
    check("ready_idle", 32'(cfg_bus.cfg_ready), 32'h1);

    // Priority: L1 beats L2
    video_on = 1'b1; layer_on = 6'b000110;
    cyc(); cyc(); @(negedge clk);
    check("prio_l1", 32'(rgb), 32'hff0);
    check("prio_valid", 32'(rgb_valid), 32'h1);
    layer_on = 6'b000000;
    cyc(); cyc(); @(negedge clk);
    check("bg_default", 32'(rgb), 32'h000);

    // Mid-frame palette write is deferred to the commit
    layer_on = 6'b000100;
    write(4'd2, 12'h123);
    cyc(); cyc(); @(negedge clk);
    check("l2_before_commit", 32'(rgb), 32'h00f);
    tick();
    cyc(); @(negedge clk);
    check("commit_cycle_pixel_old", 32'(rgb), 32'h00f);
    cyc(); @(negedge clk);
    check("after_commit", 32'(rgb), 32'h123);

    // Write held across the commit cycle
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = 4'd2; cfg_bus.cfg_data = 12'h456;
    frame_tick = 1'b1;
    #1 check("ready_low_on_tick", 32'(cfg_bus.cfg_ready), 32'h0);
    cyc();
    frame_tick = 1'b0; tick_no++;
    #1 check("ready_high_after_tick", 32'(cfg_bus.cfg_ready), 32'h1);
    cyc();
    cfg_bus.cfg_valid = 1'b0;
    cyc(); cyc(); @(negedge clk);
    check("held_not_committed", 32'(rgb), 32'h123);
    tick();
    cyc(); cyc(); @(negedge clk);
    check("held_committed", 32'(rgb), 32'h456);

    // Enable mask hides L0
    write(4'd7, 12'h03e);
    tick();
    layer_on = 6'b000011;
    cyc(); cyc(); @(negedge clk);
    check("en_mask_l1", 32'(rgb), 32'hff0);
    write(4'd7, 12'h03f);
    write(4'd12, 12'hfff);
    tick();

    // Blink on L0 with a distinct background
    write(4'd6, 12'h5a5);
    write(4'd8, 12'h001);
    tick();
    layer_on = 6'b000001;
    cyc(); cyc(); @(negedge clk);
    check("blink_start_on", 32'(rgb), 32'h0f0);
    while (tick_no < 62) begin
      tick();
      cyc(); cyc(); cyc(); @(negedge clk);
      if (tick_no == 29)      check("blink_29_on", 32'(rgb), 32'h0f0);
      else if (tick_no == 30) check("blink_30_off", 32'(rgb), 32'(BLINK_OFF_EXP));
      else if (tick_no == 60) check("blink_60_on", 32'(rgb), 32'h0f0);
    end

    // Asynchronous reset mid-line
    layer_on = 6'b000100; video_on = 1'b1;
    cyc(); cyc(); @(negedge clk);
    check("pre_reset_l2", 32'(rgb), 32'h456);
    #1 reset = 1'b0;
    #1;
    check("async_rgb", 32'(rgb), 32'h0);
    check("async_valid", 32'(rgb_valid), 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); @(negedge clk);
    check("post_reset_valid0", 32'(rgb_valid), 32'h0);
    cyc(); @(negedge clk);
    check("post_reset_l2_default", 32'(rgb), 32'h00f);
    check("post_reset_valid1", 32'(rgb_valid), 32'h1);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
